// File: rtl/deadlock_ctrl_pkg.sv
// Shared definitions for the deadlock watch controller: FSM state encoding
// and default parameter values.
package deadlock_ctrl_pkg;

    localparam int N_MON_DEF  = 4;
    localparam int THRESH_DEF = 1024;
    localparam int TS_W_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WATCH  = 3'd1,
        SCAN   = 3'd2,
        REPORT = 3'd3,
        HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/deadlock_rr_pick.sv
// Round-robin picker: lowest set request strictly above last_idx, otherwise
// the lowest set request overall; returns 0 when no request is set.
module deadlock_rr_pick
    import deadlock_ctrl_pkg::*;
#(
    parameter int N_MON = N_MON_DEF,
    parameter int IDX_W = (N_MON > 1) ? $clog2(N_MON) : 1
) (
    input  logic [N_MON-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] idx
);

    logic             hi_hit;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (i > int'(last_idx)) begin
                    hi_hit = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
        idx = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/deadlock_watch_ctrl.sv
// Deadlock watchdog: confirms THRESH consecutive blocked cycles, picks one
// blocked monitor round-robin, reports it over valid/ready and halts.
module deadlock_watch_ctrl
    import deadlock_ctrl_pkg::*;
#(
    parameter int N_MON  = N_MON_DEF,
    parameter int THRESH = THRESH_DEF,
    parameter int TS_W   = TS_W_DEF,
    localparam int IDX_W = (N_MON > 1) ? $clog2(N_MON) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [N_MON-1:0] mon_block,
    input  logic             clear,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [IDX_W-1:0] report_idx,
    output logic [N_MON-1:0] report_snap,
    output logic [TS_W-1:0]  report_ts,
    output logic             deadlock
);

    localparam int CNT_W = $clog2(THRESH);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(THRESH - 1);
    localparam logic [TS_W-1:0]  TS_MAX   = '1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MON - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_MON-1:0] snap_q, snap_d;
    logic [TS_W-1:0]  rts_q, rts_d;
    logic             dead_q, dead_d;
    logic [IDX_W-1:0] pick_idx;
    logic             any_blk;

    assign any_blk = |mon_block;

    deadlock_rr_pick #(
        .N_MON (N_MON),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (snap_q),
        .last_idx (last_q),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        last_d  = last_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        rts_d   = rts_q;
        dead_d  = dead_q;
        ts_d    = (ts_q == TS_MAX) ? ts_q : ts_q + TS_W'(1);
        case (state_q)
            IDLE: begin
                run_d = '0;
                if (enable) begin
                    state_d = WATCH;
                end
            end
            WATCH: begin
                if (!enable) begin
                    state_d = IDLE;
                    run_d   = '0;
                end else if (any_blk) begin
                    // The THRESH-th consecutive blocked cycle confirms the deadlock.
                    if (run_q == RUN_LAST) begin
                        state_d = SCAN;
                        run_d   = '0;
                        snap_d  = mon_block;
                        rts_d   = ts_q;
                    end else begin
                        run_d = run_q + CNT_W'(1);
                    end
                end else begin
                    run_d = '0;
                end
            end
            SCAN: begin
                idx_d   = pick_idx;
                valid_d = 1'b1;
                state_d = REPORT;
            end
            REPORT: begin
                if (report_ready) begin
                    valid_d = 1'b0;
                    last_d  = idx_q;
                    dead_d  = 1'b1;
                    state_d = HALT;
                end
            end
            HALT: begin
                if (clear) begin
                    dead_d  = 1'b0;
                    run_d   = '0;
                    state_d = enable ? WATCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            run_q   <= '0;
            ts_q    <= '0;
            last_q  <= LAST_RST;
            valid_q <= 1'b0;
            idx_q   <= '0;
            snap_q  <= '0;
            rts_q   <= '0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            ts_q    <= ts_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            rts_q   <= rts_d;
            dead_q  <= dead_d;
        end
    end

    assign report_valid = valid_q;
    assign report_idx   = idx_q;
    assign report_snap  = snap_q;
    assign report_ts    = rts_q;
    assign deadlock     = dead_q;

endmodule

// File: tb/tb_deadlock_watch_ctrl.sv
// Scoreboard bench for deadlock_watch_ctrl: two instances (32-bit and 4-bit
// timestamp) share stimulus and are compared against a spec-level model.
module tb_deadlock_watch_ctrl;

    localparam int N_MON  = 4;
    localparam int THRESH = 8;

    localparam int M_IDLE  = 0;
    localparam int M_WATCH = 1;
    localparam int M_REP   = 2;
    localparam int M_HALT  = 3;

    typedef struct {
        int     idx;
        int     snap;
        longint ts;
    } rep_t;

    logic       clock        = 1'b0;
    logic       reset_n      = 1'b1;
    logic       enable       = 1'b0;
    logic       clear        = 1'b0;
    logic       report_ready = 1'b0;
    logic [3:0] mon_block    = 4'b0000;

    logic        valid_a, dead_a;
    logic [1:0]  idx_a;
    logic [3:0]  snap_a;
    logic [31:0] ts_a;
    logic        valid_s, dead_s;
    logic [1:0]  idx_s;
    logic [3:0]  snap_s;
    logic [3:0]  ts_s;

    int n_checks = 0;
    int n_pass   = 0;

    rep_t   sb[$];
    rep_t   held;
    rep_t   new_rep;
    bit     have_held  = 1'b0;
    bit     prev_valid = 1'b0;

    int     m_mode;
    int     m_run;
    longint m_ts;
    int     m_last;
    longint m_edge;
    longint m_conf;
    int     m_rep_idx;
    bit     m_valid;
    bit     m_dead;

    deadlock_watch_ctrl #(.N_MON(N_MON), .THRESH(THRESH), .TS_W(32)) dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .mon_block    (mon_block),
        .clear        (clear),
        .report_valid (valid_a),
        .report_ready (report_ready),
        .report_idx   (idx_a),
        .report_snap  (snap_a),
        .report_ts    (ts_a),
        .deadlock     (dead_a)
    );

    deadlock_watch_ctrl #(.N_MON(N_MON), .THRESH(THRESH), .TS_W(4)) dut_s (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .mon_block    (mon_block),
        .clear        (clear),
        .report_valid (valid_s),
        .report_ready (report_ready),
        .report_idx   (idx_s),
        .report_snap  (snap_s),
        .report_ts    (ts_s),
        .deadlock     (dead_s)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Search upward from the monitor after the last reported one, wrapping.
    function automatic int refPick(input int snap, input int last);
        for (int k = 1; k <= N_MON; k++) begin
            int j;
            j = (last + k) % N_MON;
            if (snap[j]) return j;
        end
        return 0;
    endfunction

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic modelReset();
        m_mode    = M_IDLE;
        m_run     = 0;
        m_ts      = 0;
        m_last    = N_MON - 1;
        m_edge    = 0;
        m_conf    = 0;
        m_rep_idx = 0;
        m_valid   = 1'b0;
        m_dead    = 1'b0;
        sb.delete();
    endtask

    // One rising edge of reference behaviour, using the inputs held over it.
    task automatic modelStep();
        m_edge++;
        case (m_mode)
            M_IDLE: begin
                if (enable) begin
                    m_mode = M_WATCH;
                    m_run  = 0;
                end
            end
            M_WATCH: begin
                if (!enable) begin
                    m_mode = M_IDLE;
                    m_run  = 0;
                end else if (mon_block != 4'b0000) begin
                    m_run++;
                    if (m_run == THRESH) begin
                        new_rep.idx  = refPick(int'(mon_block), m_last);
                        new_rep.snap = int'(mon_block);
                        new_rep.ts   = m_ts;
                        sb.push_back(new_rep);
                        m_rep_idx = new_rep.idx;
                        m_conf    = m_edge;
                        m_mode    = M_REP;
                        m_run     = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            M_REP: begin
                if (m_edge >= m_conf + 2 && report_ready) begin
                    m_last = m_rep_idx;
                    m_mode = M_HALT;
                end
            end
            default: begin
                if (clear) begin
                    m_mode = enable ? M_WATCH : M_IDLE;
                    m_run  = 0;
                end
            end
        endcase
        m_ts++;
        m_valid = (m_mode == M_REP) && (m_edge >= m_conf + 1);
        m_dead  = (m_mode == M_HALT);
    endtask

    task automatic stepCycle();
        @(posedge clock);
        if (reset_n) modelStep();
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] mon, input logic clr,
                                 input logic rdy, input int cycles);
        enable       = en;
        mon_block    = mon;
        clear        = clr;
        report_ready = rdy;
        for (int c = 0; c < cycles; c++) stepCycle();
    endtask

    task automatic waitValid(input int budget);
        int waited;
        waited = 0;
        while (!valid_a && waited < budget) begin
            stepCycle();
            waited++;
        end
        checkOutput("wait_valid_timeout", valid_a, 1'b1);
    endtask

    // Monitor: compares every cycle and pops a report when one is presented.
    always @(negedge clock) begin
        if (!reset_n) begin
            checkOutput("reset_outputs_a", {valid_a, dead_a, idx_a, snap_a, ts_a}, 64'd0);
            checkOutput("reset_outputs_s", {valid_s, dead_s, idx_s, snap_s, ts_s}, 64'd0);
            prev_valid = 1'b0;
            have_held  = 1'b0;
        end else begin
            checkOutput("report_valid", valid_a, m_valid);
            checkOutput("report_valid_s", valid_s, m_valid);
            checkOutput("deadlock", dead_a, m_dead);
            checkOutput("deadlock_s", dead_s, m_dead);
            if (valid_a && !prev_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_report", valid_a, 1'b0);
                    have_held = 1'b0;
                end else begin
                    held      = sb.pop_front();
                    have_held = 1'b1;
                end
            end
            if (valid_a && have_held) begin
                checkOutput("report_idx", idx_a, held.idx);
                checkOutput("report_snap", snap_a, held.snap);
                checkOutput("report_ts", ts_a, held.ts);
                checkOutput("report_idx_s", idx_s, held.idx);
                checkOutput("report_snap_s", snap_s, held.snap);
                checkOutput("report_ts_sat", ts_s, sat4(held.ts));
            end
            prev_valid = valid_a;
        end
    end

    initial begin
        modelReset();
        mon_block = 4'b1111;
        #1 reset_n = 1'b0;
        repeat (3) stepCycle();
        reset_n = 1'b1;
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 3);

        // Confirmation timing with a single blocked monitor.
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 12);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 1);

        // Broken run: only the second run may report.
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 7);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 12);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 1);

        // Back-pressure while the blocked set keeps changing.
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 8);
        waitValid(8);
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1);
        checkOutput("bp_valid_after", valid_a, 1'b0);
        checkOutput("bp_deadlock_after", dead_a, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 1);

        // Round-robin over a repeated snapshot.
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, 4'b1010, 1'b0, 1'b1, 12);
            applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 1);
        end

        // Clear coincident with the handshake is ignored.
        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, 8);
        waitValid(8);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 4);
        checkOutput("coincident_deadlock", dead_a, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 1);

        // Randomized traffic with sticky blocked patterns.
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] mon;
            mon = mon_block;
            if ($urandom_range(0, 11) == 0) mon = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 19) != 0, mon, $urandom_range(0, 9) == 0,
                          1'($urandom_range(0, 1)), 1);
        end

        // Reset in the middle of a pending report.
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 3);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 9);
        waitValid(8);
        #2 reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_reset_valid", valid_a, 1'b0);
        checkOutput("mid_reset_valid_s", valid_s, 1'b0);
        repeat (2) stepCycle();
        reset_n = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/deadlock_watch_ctrl.md
DEADLOCK_WATCH_CTRL -- requirements
Module: deadlock_watch_ctrl

Interface
REQ-001 SHALL have parameter N_MON, default 4, meaning the number of per-instance monitor block inputs (1..32).
REQ-002 SHALL have parameter THRESH, default 1024, meaning consecutive blocked cycles that confirm a deadlock (2..65535).
REQ-003 SHALL have parameter TS_W, default 32, meaning the width of the cycle timestamp.
REQ-004 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  arms watching while high.
REQ-007 SHALL have port mon_block  in  N_MON  per-monitor block flags, one bit per monitor instance.
REQ-008 SHALL have port clear  in  1  single-cycle pulse that rearms the block after a halt.
REQ-009 SHALL have port report_valid  out  1  deadlock report is available.
REQ-010 SHALL have port report_ready  in  1  consumer accepts the report.
REQ-011 SHALL have port report_idx  out  $clog2(N_MON) (minimum 1)  index of the selected blocked monitor.
REQ-012 SHALL have port report_snap  out  N_MON  mon_block snapshot taken at confirmation.
REQ-013 SHALL have port report_ts  out  TS_W  timestamp taken at confirmation.
REQ-014 SHALL have port deadlock  out  1  sticky flag, high while halted.

Function
REQ-015 SHALL use FSM states IDLE, WATCH, SCAN, REPORT and HALT.
REQ-016 SHALL define any_blk as the OR of all mon_block bits.
REQ-017 SHALL, in IDLE, move to WATCH on enable=1, with the run counter loaded to 0.
REQ-018 SHALL, in WATCH with enable=0, return to IDLE and clear the run counter.
REQ-019 SHALL, in WATCH with any_blk=1, increment the run counter; any_blk=0 clears it to 0.
REQ-020 SHALL, in WATCH, move to SCAN on the cycle where any_blk=1 and the run counter equals THRESH-1, so the transition follows exactly THRESH consecutive blocked cycles; on that edge report_snap<=mon_block and report_ts<=timestamp.
REQ-021 SHALL, in SCAN (exactly 1 cycle), select report_idx round-robin from report_snap: the lowest set index at or above last_idx+1, wrapping to 0; last_idx resets to N_MON-1, so the first pick is the lowest set bit. Then move to REPORT.
REQ-022 SHALL, in REPORT, drive report_valid=1 and hold report_idx, report_snap and report_ts stable until report_valid&&report_ready; on that edge, last_idx<=report_idx and the state moves to HALT.
REQ-023 SHALL ignore enable and clear in SCAN and REPORT.
REQ-024 SHALL, in HALT, drive deadlock=1; clear=1 moves to WATCH if enable=1, else to IDLE, with the run counter at 0 and deadlock falling on the next cycle.
REQ-025 SHALL ignore clear outside HALT.
REQ-026 SHALL ignore a clear arriving in the same cycle as the REPORT handshake; HALT is still entered.
REQ-027 SHALL keep the timestamp free-running from reset, incrementing every cycle and saturating at all-ones without wrapping.
REQ-028 SHALL make the run counter wide enough to hold THRESH-1 and never overflow it.
REQ-029 SHALL make report_snap nonzero by construction; if it is zero anyway, report_idx SHALL be 0.
REQ-030 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force state=IDLE, run counter=0, timestamp=0, last_idx=N_MON-1, report_valid=0, report_idx=0, report_snap=0, report_ts=0 and deadlock=0.
REQ-032 SHALL, on reset asserted mid-REPORT, drop report_valid immediately with no handshake.
REQ-033 SHALL deassert reset synchronously to clock (external synchronizer), with IDLE as the first active state.

Structure
REQ-034 SHALL place the state enum (IDLE..HALT) and the default values of N_MON, THRESH and TS_W in the shared package deadlock_ctrl_pkg.
REQ-035 SHALL put the round-robin selection in one combinational sub-module, deadlock_rr_pick (inputs req[N_MON] and last_idx; output idx), instantiated once.

Verification
REQ-036 SHALL cover reset: N_MON=4, THRESH=8; hold reset_n=0 with mon_block=4'b1111 -> all outputs 0; release with enable=0 -> state stays IDLE and report_valid=0.
REQ-037 SHALL cover confirmation timing: enable=1, mon_block=4'b0100 held -> report_valid rises 2 cycles after the 8th blocked cycle (SCAN then REPORT), with report_idx=2 and report_snap=4'b0100.
REQ-038 SHALL cover a broken run: 7 blocked cycles, 1 cycle of mon_block=0, then 8 blocked cycles -> exactly one report, following the second run only.
REQ-039 SHALL cover back-pressure: report_ready=0 for 5 cycles while mon_block changes -> report_idx, report_snap and report_ts are unchanged; report_ready=1 -> next cycle report_valid=0 and deadlock=1.
REQ-040 SHALL cover round-robin: snap=4'b1010 gives idx=1; clear, repeat with 4'b1010 -> idx=3; clear, repeat -> idx=1.
REQ-041 SHALL cover simultaneous events and saturation: clear coincident with the REPORT handshake -> deadlock=1 stays until a later clear; with TS_W=4, run 20 cycles -> report_ts saturates at 4'hF.
